relm_fp_normalize: RTL and testbench
====================================

# relm_fp_normalize

Sequential post-normalisation and rounding stage for the ReLM custom floating-point datapath. It sits directly downstream of the custom ALU. It consumes the raw 32-bit mantissa word and the packed sign/exponent/flag word that the FADD and FMUL operations leave in A and B. It produces a rounded IEEE-754 single-precision word. Leading-zero removal is iterative, so latency is variable, and both sides use a valid/ready handshake.

## Interface

Parameters:
- `STEP`, default 8: maximum left-shift distance per NORM cycle, legal range 1..31.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `in_valid`, in, 1: input word pair valid.
- `in_ready`, out, 1: block can accept an input.
- `in_m`, in, 32: raw mantissa word. The nominal leading one is at bit 30; bit 31 marks a carry.
- `in_info`, in, 32: packed word. [31] sign, [30:23] exponent E, [22] inf flag, [21] zero flag, [20:0] ignored.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, 32: IEEE single-precision result.

## Operation

Value encoded at the input: (-1)^s · in_m · 2^(E-157).

States: IDLE, NORM, ROUND, DONE.
- `in_ready` = (state == IDLE).
- `out_valid` = (state == DONE).

IDLE:
- On `in_valid`, capture s, m = `in_m`, and e = E into a 10-bit signed register. Also capture the inf and zero flags.
- If either flag is set, go to ROUND. Otherwise go to NORM.

NORM, one action per cycle:
- m == 0: set zero, clear s (x−x = +0), go to ROUND.
- m[31] = 1: m ← {0, m[31:2], m[1]|m[0]}, sticky preserved; e ← e+1; go to ROUND.
- m[30] = 1: go to ROUND.
- Otherwise: let lz = leading zeros of m[30:0] and k = min(lz, STEP).
  - m ← m << k; e ← e−k.
  - If e−k < 1, set zero and go to ROUND.
  - Else if k == lz, go to ROUND.
  - Else stay in NORM.

ROUND, one cycle, writes `out_data` and goes to DONE:
- inf & zero: `out_data` = 0x7FC00000 (NaN).
- inf only: {s, 0xFF, 23'd0}.
- zero only: {s, 31'd0}. Denormals are flushed.
- Otherwise, round to nearest even:
  - frac = m[29:7], guard g = m[6], sticky st = |m[5:0].
  - up = g & (st | m[7]).
  - {c, f} = {1, frac} + up. If c = 1, f ← 0 and e ← e+1.
  - If e ≥ 255, output {s, 0xFF, 0}. Else output {s, e[7:0], f}.

DONE:
- Hold `out_data` stable while `out_ready` is low.
- On `out_ready`, go to IDLE. `out_data` keeps its value until the next ROUND.

## Timing

Latency is counted as clock edges from the accepting edge to the edge that raises `out_valid`:
- Special input (inf/zero flag set): 1.
- Normal input: n+1, where n = max(1, ceil(lz/STEP)) NORM cycles.
  - m[31] or m[30] already set: n = 1.

Throughput:
- A new input is accepted at most one cycle after the output handshake, since the block passes through IDLE.
- No input/output overlap.

Reset values (asynchronous on `rst` rising, held while high):
- state = IDLE.
- `in_ready` = 1 while `rst` is low.
- `out_valid` = 0.
- `out_data` = 0x00000000.
- Internal m, e, s and flags cleared.

Other timing rules:
- Reset mid-NORM or mid-DONE aborts the operation; no output is produced.
- `in_valid` is ignored outside IDLE. The upstream must hold its data until `in_ready` is seen.
- `out_valid` never drops without `out_ready`.

## Test plan

- 1.0+1.0: `in_m`=0x80000000, `in_info`=0x3F800000 → `out_data` 0x40000000; `out_valid` 2 edges after accept.
- Cancellation, STEP=8: `in_m`=0x00000040, E=0x7F → 3 NORM cycles; `out_data` 0x33800000 at edge 4. Same `in_m` with E=0x02 → 0x00000000 (underflow). `in_m`=0 → 0x00000000.
- Rounding:
  - `in_m`=0x40000040, E=0x7F → 0x3F800000 (tie, even, no round-up).
  - `in_m`=0x400000C0 → 0x3F800002.
  - `in_m`=0x40000041 → 0x3F800001.
  - `in_m`=0x7FFFFFC0 → 0x40000000 (carry into exponent).
- Overflow and specials:
  - E=0xFE, `in_m`=0x80000000 → 0x7F800000.
  - `in_info`=0x80400000 (inf, sign 1) → 0xFF800000, latency 1.
  - `in_info`=0x00600000 (inf & zero) → 0x7FC00000.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid` and `out_data` stable, `in_ready`=0, and a new `in_valid` is ignored. Release → one handshake, then IDLE.
- Reset: assert `rst` during the second NORM cycle → `out_valid`=0 and `out_data`=0 immediately. After release, `in_ready`=1 and the next input is processed normally.

Source files
------------

// File: rtl/relm_fp_normalize.sv
// relm_fp_normalize: post-normalisation and rounding stage for the ReLM
// floating-point datapath. Takes the raw ALU mantissa plus the packed
// sign/exponent/flag word, removes leading zeros a bounded number of bits
// per cycle, rounds to nearest-even and emits an IEEE-754 single word.
// Valid/ready handshake on both sides; one operation in flight at a time.
module relm_fp_normalize #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_m,
  input  logic [31:0] in_info,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t             state, state_nxt;
  logic        [31:0] m, m_nxt;
  logic signed [9:0]  e, e_nxt;
  logic               s, s_nxt;
  logic               inf, inf_nxt;
  logic               zero, zero_nxt;
  logic        [31:0] data_nxt;

  logic        [4:0]  lz;
  logic        [4:0]  k;
  logic signed [9:0]  e_sub;
  logic               up;
  logic        [24:0] rsum;
  logic signed [9:0]  e_rnd;
  logic        [22:0] frac_rnd;

  // The low info bits carry nothing for this stage.
  logic unused_info;
  assign unused_info = ^in_info[20:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Leading-zero count of m[30:0]; the highest set bit wins, 31 if none.
  always_comb begin
    lz = 5'd31;
    for (int i = 0; i < 31; i++) begin
      if (m[i]) lz = 5'(30 - i);
    end
  end

  // Shift distance for this NORM cycle is capped at STEP.
  assign k     = (lz < STEP_W) ? lz : STEP_W;
  assign e_sub = e - $signed({5'd0, k});

  // Round to nearest even on the 24-bit significand with the hidden one
  // restored, so a carry out of bit 23 means the significand overflowed.
  assign up       = m[6] & ((|m[5:0]) | m[7]);
  assign rsum     = {1'b0, 1'b1, m[29:7]} + 25'(up);
  assign e_rnd    = rsum[24] ? (e + 10'sd1) : e;
  assign frac_rnd = rsum[24] ? 23'd0 : rsum[22:0];

  // Next-state and datapath updates for every FSM state.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_nxt = state;
    m_nxt     = m;
    e_nxt     = e;
    s_nxt     = s;
    inf_nxt   = inf;
    zero_nxt  = zero;
    data_nxt  = out_data;

    case (state)
      IDLE: begin
        if (in_valid) begin
          s_nxt     = in_info[31];
          m_nxt     = in_m;
          e_nxt     = $signed({2'b00, in_info[30:23]});
          inf_nxt   = in_info[22];
          zero_nxt  = in_info[21];
          state_nxt = (in_info[22] | in_info[21]) ? ROUND : NORM;
        end
      end

      NORM: begin
        if (m == 32'd0) begin
          // Exact cancellation always yields +0.
          zero_nxt  = 1'b1;
          s_nxt     = 1'b0;
          state_nxt = ROUND;
        end else if (m[31]) begin
          // Carry out of the adder: shift right once, keep the sticky bit.
          m_nxt     = {1'b0, m[31:2], m[1] | m[0]};
          e_nxt     = e + 10'sd1;
          state_nxt = ROUND;
        end else if (m[30]) begin
          state_nxt = ROUND;
        end else begin
          m_nxt = m << k;
          e_nxt = e_sub;
          if (e_sub < 10'sd1) begin
            // Result would be denormal: flush to zero, sign kept.
            zero_nxt  = 1'b1;
            state_nxt = ROUND;
          end else if (k == lz) begin
            state_nxt = ROUND;
          end
        end
      end

      ROUND: begin
        if (inf && zero) begin
          data_nxt = 32'h7FC0_0000;
        end else if (inf) begin
          data_nxt = {s, 8'hFF, 23'd0};
        end else if (zero) begin
          data_nxt = {s, 31'd0};
        end else if (e_rnd >= 10'sd255) begin
          data_nxt = {s, 8'hFF, 23'd0};
        end else begin
          data_nxt = {s, e_rnd[7:0], frac_rnd};
        end
        state_nxt = DONE;
      end

      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m        <= '0;
      e        <= '0;
      s        <= 1'b0;
      inf      <= 1'b0;
      zero     <= 1'b0;
      out_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the pre-edge state, independent of statement order.
      state    <= state_nxt;
      m        <= m_nxt;
      e        <= e_nxt;
      s        <= s_nxt;
      inf      <= inf_nxt;
      zero     <= zero_nxt;
      out_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_relm_fp_normalize.sv
// Self-checking bench for relm_fp_normalize: directed cases with known
// answers, randomized traffic against an arithmetic reference model, a
// backpressure episode and a mid-operation reset. A scoreboard queue holds
// expected results; a monitor pops and compares on each output handshake.
module tb_relm_fp_normalize;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_m;
  logic [31:0] in_info;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  relm_fp_normalize #(.STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_info   (in_info),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;
  bit   hold_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value = m * 2^(E-157); normalise so the leading one sits at
  // 2^30, flush anything below exponent 1, then round the 24-bit
  // significand to nearest even by comparing the dropped bits with one half.
  function automatic void model(input logic [31:0] m, input logic [31:0] info,
                                output logic [31:0] d, output int lat);
    logic        s;
    int          e, lz, n;
    longint      mm, mant, rem;
    logic [7:0]  eb;
    logic [22:0] fb;
    s = info[31];
    e = int'(info[30:23]);
    if (info[22] && info[21]) begin d = 32'h7FC0_0000; lat = 1; return; end
    if (info[22]) begin d = {s, 8'hFF, 23'd0}; lat = 1; return; end
    if (info[21]) begin d = {s, 31'd0}; lat = 1; return; end
    lat = 2;
    if (m == 32'd0) begin d = 32'd0; return; end
    mm = longint'(m);
    if (m[31]) begin
      mm = (mm / 2) | (mm % 2);
      e  = e + 1;
    end else begin
      lz = 0;
      while (mm < 64'd1073741824) begin
        mm = mm * 2;
        lz++;
      end
      n = (((lz < e) ? lz : e) + STEP - 1) / STEP;
      if (n < 1) n = 1;
      lat = n + 1;
      e = e - lz;
      if (e < 1) begin d = {s, 31'd0}; return; end
    end
    mant = mm / 128;
    rem  = mm % 128;
    if (rem > 64 || (rem == 64 && (mant % 2) == 1)) mant = mant + 1;
    if (mant == 64'd16777216) begin
      mant = mant / 2;
      e    = e + 1;
    end
    if (e >= 255) begin
      d = {s, 8'hFF, 23'd0};
    end else begin
      eb = 8'(e);
      fb = 23'(mant);
      d  = {s, eb, fb};
    end
  endfunction

  // mode 0: no expectation (aborted op), 1: reference model, 2: given values.
  task automatic send(input logic [31:0] m, input logic [31:0] info, input int mode,
                      input logic [31:0] xd, input int xl);
    exp_t x;
    int   b = 0;
    @(posedge clk); #1;
    in_m     = m;
    in_info  = info;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      b++;
    end while (!in_ready && b < 200);
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (mode == 1) begin
      model(m, info, x.data, x.lat);
    end else begin
      x.data = xd;
      x.lat  = xl;
    end
    x.acc = cyc;
    if (mode != 0) q.push_back(x);
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() != 0 && b < 2000) begin
      @(posedge clk);
      b++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Random consumer readiness unless the main sequence takes control.
  always @(posedge clk) begin
    #2;
    if (!hold_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on first sight of out_valid, data on the handshake.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got out_valid=1 data=%h expected no output", out_data);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        end
        if (out_ready) begin
          check("data", out_data, q[0].data);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rm, ri, r;
    int b;
    rst = 1'b1;
    in_valid = 1'b0;
    in_m = '0;
    in_info = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Directed cases with known results and latencies.
    send(32'h8000_0000, 32'h3F80_0000, 2, 32'h4000_0000, 2);
    send(32'h0000_0040, 32'h3F80_0000, 2, 32'h3380_0000, 4);
    send(32'h0000_0040, 32'h0100_0000, 2, 32'h0000_0000, 2);
    send(32'h0000_0000, 32'h3F80_0000, 2, 32'h0000_0000, 2);
    send(32'h4000_0040, 32'h3F80_0000, 2, 32'h3F80_0000, 2);
    send(32'h4000_00C0, 32'h3F80_0000, 2, 32'h3F80_0002, 2);
    send(32'h4000_0041, 32'h3F80_0000, 2, 32'h3F80_0001, 2);
    send(32'h7FFF_FFC0, 32'h3F80_0000, 2, 32'h4000_0000, 2);
    send(32'h8000_0000, 32'h7F00_0000, 2, 32'h7F80_0000, 2);
    send(32'h1234_5678, 32'h8040_0000, 2, 32'hFF80_0000, 1);
    send(32'h1234_5678, 32'h0060_0000, 2, 32'h7FC0_0000, 1);
    send(32'h1234_5678, 32'h8020_0000, 2, 32'h8000_0000, 1);
    drain();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      r  = $urandom;
      rm = r >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rm = 32'd0;
      ri = $urandom;
      if ($urandom_range(0, 9) != 0) ri[22:21] = 2'b00;
      send(rm, ri, 1, 32'd0, 0);
    end
    drain();

    // Backpressure: result held, new input ignored, single handshake.
    @(posedge clk); #1;
    hold_ready = 1'b1;
    out_ready  = 1'b0;
    send(32'h8000_0000, 32'h3F80_0000, 2, 32'h4000_0000, 2);
    b = 0;
    while (!out_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("bp_valid_rise", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_m     = 32'h4000_0000;
      in_info  = 32'h4000_0000;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", out_data, 32'h4000_0000);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check("bp_after_ready", {31'd0, in_ready}, 32'd1);
    check("bp_data_kept", out_data, 32'h4000_0000);
    repeat (4) @(posedge clk);
    #1;
    check("bp_no_extra", {31'd0, out_valid}, 32'd0);
    check("bp_queue", 32'(q.size()), 32'd0);
    hold_ready = 1'b0;

    // Reset during the second NORM cycle of a three-cycle normalisation.
    send(32'h8000_0000, 32'h3F80_0000, 2, 32'h4000_0000, 2);
    drain();
    send(32'h0000_0040, 32'h3F80_0000, 0, 32'd0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h4000_0041, 32'h3F80_0000, 2, 32'h3F80_0001, 2);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
